// File: rtl/load_store_unit.sv
// Load/store front end for a word-ported, synchronous-read data memory.
// Big-endian byte lanes; sub-word stores use read-modify-write.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 5120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, MRG, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept, req_err, f3_ok, misal, oor, is_sw;
  logic [31:0] aligned, ext, merged, bw, hw;
  logic [4:0]  bsh, hsh;

  assign req_ready = !reset && (state_q == IDLE || state_q == RESP);
  assign accept    = req_valid && req_ready;
  assign aligned   = {req_addr[31:2], 2'b00};

  assign f3_ok = req_load
               ? (req_funct3 != 3'b011 && req_funct3[2:1] != 2'b11)
               : (req_funct3 <= 3'b010);
  assign misal = (req_funct3[1:0] == 2'b01 && req_addr[0])
              || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign oor     = req_addr >= 32'(MEM_BYTES);
  assign req_err = !f3_ok || misal || oor;
  assign is_sw   = req_store && !req_err && req_funct3 == 3'b010;

  // Shift amounts that bring the addressed lane down to bit 0
  assign bsh = 5'd24 - {off_q, 3'b000};
  assign hsh = 5'd16 - {off_q, 3'b000};
  assign bw  = mem_rdata >> bsh;
  assign hw  = mem_rdata >> hsh;

  always_comb begin
    ext = mem_rdata;
    if (!f3_q[1]) begin
      if (f3_q[0])
        ext = f3_q[2] ? {16'b0, hw[15:0]} : {{16{hw[15]}}, hw[15:0]};
      else
        ext = f3_q[2] ? {24'b0, bw[7:0]} : {{24{bw[7]}}, bw[7:0]};
    end
  end

  always_comb begin
    if (f3_q[0])
      merged = (mem_rdata & ~(32'h0000_FFFF << hsh))
             | ({16'b0, wdata_q} << hsh);
    else
      merged = (mem_rdata & ~(32'h0000_00FF << bsh))
             | ({24'b0, wdata_q[7:0]} << bsh);
  end

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      RD: begin
        rdata_d = ext;
        state_d = RESP;
      end
      MRG:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      f3_d    = req_funct3;
      off_d   = req_addr[1:0];
      wdata_d = req_wdata[15:0];
      addr_d  = aligned;
      rdata_d = '0;
      err_d   = req_err;
      if (req_err || is_sw) state_d = RESP;
      else if (req_load)    state_d = RD;
      else                  state_d = MRG;
    end
  end

  always_comb begin
    mem_addr  = accept ? aligned : addr_q;
    mem_we    = 1'b0;
    mem_wdata = merged;
    if (accept && is_sw) begin
      mem_we    = 1'b1;
      mem_wdata = req_wdata;
    end else if (state_q == MRG && !reset) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      f3_q    <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_valid = state_q == RESP;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage front end that sits between the EX/MEM pipeline register and the byte-addressed, word-ported, synchronous-read `DataMemory`. It takes one load or store request at a time and accepts all RV32I widths (`lb`/`lh`/`lw`/`lbu`/`lhu`/`sb`/`sh`/`sw`). For loads it issues the word read, then extracts and sign- or zero-extends the result. For sub-word stores it performs read-modify-write, because the memory only writes whole 4-byte groups.

## Interface
- `MEM_BYTES`, default 5120: data memory size in bytes. A request with `req_addr >= MEM_BYTES` is out of range.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept this cycle. Accept = `req_valid && req_ready`.
- `req_load`  in  1  request is a load.
- `req_store`  in  1  request is a store. Exactly one of `req_load`/`req_store` is set when valid.
- `req_funct3`  in  3  RV32I funct3.
  - Loads: 000 `lb`, 001 `lh`, 010 `lw`, 100 `lbu`, 101 `lhu`.
  - Stores: 000 `sb`, 001 `sh`, 010 `sw`.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, taken from the LSBs.
- `resp_valid`  out  1  one-cycle completion pulse. No backpressure.
- `resp_rdata`  out  32  extended load result; 0 for stores and errors.
- `resp_err`  out  1  misaligned, out-of-range or illegal funct3.
- `mem_we`  out  1  to `DataMemory` `MemWrite`.
- `mem_addr`  out  32  to `DataMemory` `Address`; always word-aligned (`{addr[31:2],2'b00}`).
- `mem_wdata`  out  32  to `DataMemory` `Write_data`.
- `mem_rdata`  in  32  from `DataMemory` `Read_data`; valid one cycle after the address is presented.

## Operation
- **Byte order (big-endian within a word):** the byte at `addr` with offset `o = addr[1:0]` occupies `word[31-8o -: 8]`. A halfword at `o ∈ {0,2}` occupies `word[31-8o -: 16]`.
- **Errors:**
  - Halfword access with `addr[0]` = 1.
  - Word access with `addr[1:0]` ≠ 0.
  - `addr >= MEM_BYTES`.
  - Load funct3 ∈ {011, 110, 111}, or store funct3 > 010.
  - Effect: no memory write, `resp_err` = 1, `resp_rdata` = 0.
- **State machine: `IDLE`, `RD`, `MRG`, `RESP`.**
  - `IDLE` and `RESP` have `req_ready` = 1. `RD` and `MRG` have `req_ready` = 0.
  - On accept:
    - error → `RESP`
    - `sw` → `RESP`; `mem_we` = 1 in the accept cycle with `mem_wdata = req_wdata`
    - load → `RD`
    - `sb`/`sh` → `MRG`
    - With no accept, `RESP` → `IDLE`.
  - `RD`: capture the extracted, extended `mem_rdata` into `resp_rdata`, then → `RESP`.
  - `MRG`: drive `mem_we` = 1 with the held aligned address and `mem_wdata` = `mem_rdata` with the target byte/halfword lanes replaced by `wdata[7:0]`/`wdata[15:0]`, then → `RESP`.
  - `RESP`: `resp_valid` = 1.
- **Registering:** opcode, funct3, offset and store data are registered at accept. `mem_addr` is driven combinationally from `req_addr` in accept cycles and from the held address otherwise.
- **Reset:** state `IDLE`, `resp_valid`/`resp_err` = 0, `resp_rdata` = 0. While `reset` is high, `mem_we` and `req_ready` are forced to 0.

## Timing
- Accept at cycle T.
  - `sw` or error: `resp_valid` at T+1.
  - Loads: read issued at T, data extracted in T+1, `resp_valid` at T+2.
  - `sb`/`sh`: read at T, write at T+1 (commits on the T+1→T+2 edge), `resp_valid` at T+2.
- A new request may be accepted in the `RESP` cycle, giving back-to-back throughput. It observes all prior writes, because they committed at or before the edge entering `RESP`.
- `mem_we` is never asserted in `RD`, `RESP` without a `sw` accept, or `IDLE` without a `sw` accept.
- Reset asserted in `RD`/`MRG` aborts the operation: no write at that edge, no `resp_valid` afterwards.

## Test plan
- **Word store and load:** reset, then `sw` addr 0x10 data 0xA1B2C3D4.
  - Required: `mem_we`=1 and `mem_addr`=0x10 in the accept cycle; `resp_valid`=1, `resp_err`=0 at T+1.
  - Then `lw` 0x10 → `resp_rdata`=0xA1B2C3D4 at T+2.
- **Load extraction** (memory word 0x10 = 0xA1B2C3D4):
  - `lb` 0x11 → 0xFFFFFFB2
  - `lbu` 0x11 → 0x000000B2
  - `lh` 0x12 → 0xFFFFC3D4
  - `lhu` 0x10 → 0x0000A1B2
  - `lb` 0x13 → 0xFFFFFFD4
- **Sub-word stores:**
  - `sb` 0x13 data 0xEE: `req_ready`=0 at T+1, `mem_we`=1 at T+1 with `mem_wdata`=0xA1B2C3EE, `resp_valid` at T+2.
  - `sh` 0x10 data 0x1234 → word becomes 0x1234C3EE.
- **Errors:** each of `lw` 0x12, `sh` 0x11, `lw` 0x1400, load funct3=011 → `resp_valid`=1, `resp_err`=1, `resp_rdata`=0 at T+1; `mem_we` never asserted.
- **Back-to-back:** `sb` 0x10 data 0x77, then `lw` 0x10 accepted in the `RESP` cycle → `resp_rdata`=0x7734C3EE.
- **Reset mid-operation:** `sb` accepted, reset during `MRG` → memory word unchanged, `resp_valid`=0, `req_ready`=1 the cycle after reset deasserts.
